// File: rtl/rf_write_arbiter_pkg.sv
// rf_write_arbiter_pkg: shared register-file widths and arbiter helpers
package rf_write_arbiter_pkg;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_DATA_WIDTH = 32;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;
  localparam int WB_ENTRY_WIDTH = REG_ADDR_WIDTH + REG_DATA_WIDTH;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: WB, mul/div, scoreboard and register-file write signals
interface rf_write_arbiter_if
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W = REG_DATA_WIDTH,
  parameter int ADDR_W = REG_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 4
);
  logic pipe_we;
  logic [ADDR_W-1:0] pipe_waddr;
  logic [DATA_W-1:0] pipe_wdata;
  logic md_valid;
  logic md_ready;
  logic [ADDR_W-1:0] md_waddr;
  logic [DATA_W-1:0] md_wdata;
  logic iss_valid;
  logic [ADDR_W-1:0] iss_waddr;
  logic [ADDR_W-1:0] chk_addr1;
  logic [ADDR_W-1:0] chk_addr2;
  logic chk_busy1;
  logic chk_busy2;
  logic stall_req;
  logic rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [cnt_w(FIFO_DEPTH)-1:0] pending_cnt;
  modport master (
    input pipe_we, pipe_waddr, pipe_wdata, md_valid, md_waddr, md_wdata,
          iss_valid, iss_waddr, chk_addr1, chk_addr2,
    output md_ready, chk_busy1, chk_busy2, stall_req, rf_we, rf_waddr, rf_wdata, pending_cnt
  );
  modport slave (
    output pipe_we, pipe_waddr, pipe_wdata, md_valid, md_waddr, md_wdata,
           iss_valid, iss_waddr, chk_addr1, chk_addr2,
    input md_ready, chk_busy1, chk_busy2, stall_req, rf_we, rf_waddr, rf_wdata, pending_cnt
  );
endinterface

// File: rtl/rf_write_arbiter_wb_result_fifo.sv
// wb_result_fifo: power-of-two sync FIFO holding buffered mul/div write-backs
module wb_result_fifo #(
  parameter int W = 37,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign full = count == ($clog2(DEPTH)+1)'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
  // storage needs no reset: occupancy alone decides which entries are live
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= din;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + ($clog2(DEPTH)+1)'(push) - ($clog2(DEPTH)+1)'(pop);
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: merges WB and buffered mul/div results onto the register-file write port
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W = REG_DATA_WIDTH,
  parameter int ADDR_W = REG_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input logic clk,
  input logic rst_n,
  rf_write_arbiter_if.master bus
);
  localparam int NREG = 1 << ADDR_W;
  localparam int AGE_W = $clog2(STARVE_MAX + 1);
  logic full, empty, push, pop, pipe_win;
  logic [ADDR_W+DATA_W-1:0] head;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [cnt_w(FIFO_DEPTH)-1:0] count;
  logic [NREG-1:0] busy, busy_nxt;
  logic [AGE_W-1:0] age;
  assign {head_addr, head_data} = head;
  assign pipe_win = bus.pipe_we && bus.pipe_waddr != '0;
  assign push = bus.md_valid && !full;
  assign pop = !pipe_win && !empty;
  assign bus.md_ready = !full;
  assign bus.pending_cnt = count;
  assign bus.chk_busy1 = busy[bus.chk_addr1];
  assign bus.chk_busy2 = busy[bus.chk_addr2];
  assign busy_nxt = ((busy & ~(NREG'(pop) << head_addr)) | (NREG'(bus.iss_valid) << bus.iss_waddr)) & ~NREG'(1);
  wb_result_fifo #(.W(ADDR_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din({bus.md_waddr, bus.md_wdata}),
    .full(full),
    .empty(empty),
    .count(count),
    .head(head)
  );
  // one registered write per cycle; a popped x0 entry retires without writing
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.rf_we <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
    end else begin
      bus.rf_we <= pipe_win || (pop && head_addr != '0);
      if (pipe_win || pop) begin
        bus.rf_waddr <= pipe_win ? bus.pipe_waddr : head_addr;
        bus.rf_wdata <= pipe_win ? bus.pipe_wdata : head_data;
      end
    end
  // busy scoreboard: issue sets, pop clears, set wins on collision
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else busy <= busy_nxt;
  // head age saturates at STARVE_MAX; stall holds until the head finally pops
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      age <= '0;
      bus.stall_req <= 1'b0;
    end else begin
      age <= (pop || empty) ? '0 : (age == AGE_W'(STARVE_MAX) ? age : age + 1'b1);
      bus.stall_req <= pop ? 1'b0 : (bus.stall_req || age == AGE_W'(STARVE_MAX));
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: table, directed and random checks against a queue-based model
module tb_rf_write_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  localparam int DEPTH = 4;
  localparam int SMAX = 8;
  typedef struct {
    logic [4:0] a;
    logic [31:0] d;
  } ent_t;
  typedef struct {
    logic we;
    logic [4:0] a;
    logic [31:0] d;
    logic ewe;
    logic [4:0] ea;
    logic [31:0] ed;
  } vec_t;
  ent_t q[$];
  bit busy_m[32];
  int age_m;
  bit stall_m;
  bit exp_we;
  logic [4:0] exp_addr;
  logic [31:0] exp_data;
  vec_t vt[5];
  int k;

  rf_write_arbiter_if #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH)) bus ();
  rf_write_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    foreach (busy_m[i]) busy_m[i] = 0;
    age_m = 0;
    stall_m = 0;
    exp_we = 0;
    exp_addr = 0;
    exp_data = 0;
  endtask

  task automatic idle_inputs();
    bus.pipe_we = 0;
    bus.pipe_waddr = 0;
    bus.pipe_wdata = 0;
    bus.md_valid = 0;
    bus.md_waddr = 0;
    bus.md_wdata = 0;
    bus.iss_valid = 0;
    bus.iss_waddr = 0;
  endtask

  task automatic cycle();
    bit pw, pp, was_empty, ready;
    ent_t h;
    #1;
    check("md_ready", bus.md_ready, q.size() != DEPTH);
    check("pending_cnt", bus.pending_cnt, q.size());
    check("stall_req", bus.stall_req, stall_m);
    check("chk_busy1", bus.chk_busy1, busy_m[bus.chk_addr1]);
    check("chk_busy2", bus.chk_busy2, busy_m[bus.chk_addr2]);
    pw = bus.pipe_we && bus.pipe_waddr != 0;
    was_empty = q.size() == 0;
    ready = q.size() != DEPTH;
    pp = !pw && !was_empty;
    if (pw) begin
      exp_we = 1;
      exp_addr = bus.pipe_waddr;
      exp_data = bus.pipe_wdata;
    end else if (pp) begin
      h = q.pop_front();
      exp_we = h.a != 0;
      if (exp_we) begin
        exp_addr = h.a;
        exp_data = h.d;
      end
      busy_m[h.a] = 0;
    end else exp_we = 0;
    if (bus.iss_valid) busy_m[bus.iss_waddr] = 1;
    busy_m[0] = 0;
    if (bus.md_valid && ready) q.push_back('{bus.md_waddr, bus.md_wdata});
    if (pp) stall_m = 0;
    else if (age_m >= SMAX) stall_m = 1;
    if (pp || was_empty) age_m = 0;
    else if (age_m < SMAX) age_m++;
    @(posedge clk);
    #1;
    check("rf_we", bus.rf_we, exp_we);
    if (exp_we) begin
      check("rf_waddr", bus.rf_waddr, exp_addr);
      check("rf_wdata", bus.rf_wdata, exp_data);
    end
  endtask

  initial begin
    idle_inputs();
    bus.chk_addr1 = 0;
    bus.chk_addr2 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_rf_we", bus.rf_we, 0);
    check("rst_rf_waddr", bus.rf_waddr, 0);
    check("rst_rf_wdata", bus.rf_wdata, 0);
    check("rst_pending", bus.pending_cnt, 0);
    check("rst_md_ready", bus.md_ready, 1);
    check("rst_stall", bus.stall_req, 0);
    rst_n = 1;

    vt[0] = '{1, 5, 32'hDEADBEEF, 1, 5, 32'hDEADBEEF};
    vt[1] = '{1, 0, 32'h00001234, 0, 0, 0};
    vt[2] = '{1, 31, 32'hFFFFFFFF, 1, 31, 32'hFFFFFFFF};
    vt[3] = '{0, 3, 32'h00000055, 0, 0, 0};
    vt[4] = '{1, 1, 32'h00000000, 1, 1, 32'h00000000};
    for (int i = 0; i < 5; i++) begin
      bus.pipe_we = vt[i].we;
      bus.pipe_waddr = vt[i].a;
      bus.pipe_wdata = vt[i].d;
      cycle();
      check($sformatf("vec%0d_we", i), bus.rf_we, vt[i].ewe);
      if (vt[i].ewe) begin
        check($sformatf("vec%0d_addr", i), bus.rf_waddr, vt[i].ea);
        check($sformatf("vec%0d_data", i), bus.rf_wdata, vt[i].ed);
      end
    end

    idle_inputs();
    bus.chk_addr1 = 7;
    bus.iss_valid = 1;
    bus.iss_waddr = 7;
    cycle();
    bus.iss_valid = 0;
    bus.md_valid = 1;
    bus.md_waddr = 7;
    bus.md_wdata = 32'h12;
    cycle();
    bus.md_valid = 0;
    #1;
    check("busy7_held", bus.chk_busy1, 1);
    cycle();
    check("md_lat_we", bus.rf_we, 1);
    check("md_lat_addr", bus.rf_waddr, 7);
    check("md_lat_data", bus.rf_wdata, 32'h12);
    check("busy7_clr", bus.chk_busy1, 0);

    k = 0;
    for (int i = 0; i < 14; i++) begin
      bus.pipe_we = 1;
      bus.pipe_waddr = 5'(10 + i % 8);
      bus.pipe_wdata = i;
      bus.md_valid = 1;
      bus.md_waddr = 5'(20 + k);
      bus.md_wdata = 32'h100 + k;
      if (q.size() != DEPTH) k++;
      cycle();
    end
    check("full_cnt", bus.pending_cnt, 4);
    check("full_ready", bus.md_ready, 0);
    check("starve_stall", bus.stall_req, 1);
    bus.pipe_we = 0;
    cycle();
    check("stall_drop", bus.stall_req, 0);
    check("starve_pop_addr", bus.rf_waddr, 20);
    for (int i = 0; i < 8; i++) begin
      bus.md_valid = k < 5;
      bus.md_waddr = 5'(20 + k);
      bus.md_wdata = 32'h100 + k;
      if (k < 5 && q.size() != DEPTH) k++;
      cycle();
    end

    idle_inputs();
    bus.chk_addr1 = 9;
    bus.iss_valid = 1;
    bus.iss_waddr = 9;
    bus.md_valid = 1;
    bus.md_waddr = 9;
    bus.md_wdata = 32'h99;
    cycle();
    bus.md_valid = 0;
    cycle();
    bus.iss_valid = 0;
    #1;
    check("busy9_setwins", bus.chk_busy1, 1);
    cycle();

    k = 0;
    bus.pipe_we = 1;
    bus.pipe_waddr = 2;
    while (q.size() != DEPTH) begin
      bus.md_valid = 1;
      bus.md_waddr = 5'(1 + k % 31);
      bus.md_wdata = 32'hA000 + k;
      k++;
      cycle();
    end
    bus.pipe_we = 0;
    for (int i = 0; i < 12; i++) begin
      bus.md_waddr = 5'(1 + k % 31);
      bus.md_wdata = 32'hA000 + k;
      if (q.size() != DEPTH) k++;
      cycle();
    end
    idle_inputs();
    repeat (6) cycle();

    for (int i = 0; i < 400; i++) begin
      bus.pipe_we = (i < 200) ? ($urandom % 2 == 1) : ($urandom % 8 != 0);
      bus.pipe_waddr = 5'($urandom % 4 == 0 ? 0 : $urandom);
      bus.pipe_wdata = $urandom;
      bus.md_valid = $urandom % 2 == 1;
      bus.md_waddr = 5'($urandom % 6 == 0 ? 0 : $urandom);
      bus.md_wdata = $urandom;
      bus.iss_valid = $urandom % 3 == 0;
      bus.iss_waddr = 5'($urandom);
      bus.chk_addr1 = 5'($urandom);
      bus.chk_addr2 = bus.md_waddr;
      cycle();
    end
    idle_inputs();
    repeat (6) cycle();

    bus.pipe_we = 1;
    bus.pipe_waddr = 4;
    bus.pipe_wdata = 32'h44;
    for (int i = 0; i < 3; i++) begin
      bus.md_valid = 1;
      bus.md_waddr = 5'(11 + i);
      bus.md_wdata = 32'hB0 + i;
      bus.iss_valid = 1;
      bus.iss_waddr = 5'(11 + i);
      cycle();
    end
    check("pre_rst_cnt", bus.pending_cnt, 3);
    check("pre_rst_we", bus.rf_we, 1);
    idle_inputs();
    bus.chk_addr1 = 11;
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check("mid_rst_we", bus.rf_we, 0);
    check("mid_rst_waddr", bus.rf_waddr, 0);
    check("mid_rst_wdata", bus.rf_wdata, 0);
    check("mid_rst_cnt", bus.pending_cnt, 0);
    check("mid_rst_ready", bus.md_ready, 1);
    check("mid_rst_busy", bus.chk_busy1, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
